// File: rtl/inverter_serial_if.sv
// Request/result bundle for the bit-serial inverter: operand and mode in,
// packed result, overflow flag and handshake status out.
interface inverter_serial_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [1:0]         mode;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] out;
    logic               ovf;

    modport master (
        output start, a, mode,
        input  ready, done, out, ovf
    );

    modport slave (
        input  start, a, mode,
        output ready, done, out, ovf
    );
endinterface

// File: rtl/inverter_serial.sv
// Bit-serial complement/negate/passthrough unit: processes one operand bit per
// clock, LSB first, and publishes {operand, result} with a one-cycle done pulse.
module inverter_serial #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inverter_serial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [1:0]         mode_reg;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   result_next;
    logic               seen_one;
    logic [2*WIDTH-1:0] out_reg;
    logic               ovf_reg;
    logic               cur_bit;
    logic               res_bit;
    logic               last_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Negate without a carry chain: copy bits up to and including the lowest
    // set bit, invert everything above it.
    always_comb begin
        state_next  = state;
        cur_bit     = a_reg[cnt];
        res_bit     = ~cur_bit;
        last_bit    = (cnt == LAST);
        result_next = result;
        case (mode_reg)
            2'b01:   res_bit = seen_one ? ~cur_bit : cur_bit;
            2'b10:   res_bit = cur_bit;
            default: res_bit = ~cur_bit;
        endcase
        result_next[cnt] = res_bit;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            mode_reg <= '0;
            cnt      <= '0;
            result   <= '0;
            seen_one <= 1'b0;
            out_reg  <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.a;
                        mode_reg <= bus.mode;
                        cnt      <= '0;
                        result   <= '0;
                        seen_one <= 1'b0;
                    end
                end
                RUN: begin
                    result   <= result_next;
                    seen_one <= seen_one | cur_bit;
                    if (last_bit) begin
                        out_reg <= {a_reg, result_next};
                        // A lone top bit with nothing set below it is the
                        // most-negative value, whose negation overflows.
                        ovf_reg <= (mode_reg == 2'b01) && cur_bit && !seen_one;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.out   = out_reg;
    assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_inverter_serial.sv
// Randomised and directed bench for inverter_serial, checked against an
// arithmetic reference model of complement/negate/passthrough.
module tb_inverter_serial;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    inverter_serial_if #(.WIDTH(W)) bus ();

    inverter_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] modelResult(input logic [W-1:0] av, input logic [1:0] mv);
        logic [W-1:0] zero;
        zero = '0;
        case (mv)
            2'd1:    return zero - av;
            2'd2:    return av;
            default: return ~av;
        endcase
    endfunction

    function automatic logic modelOvf(input logic [W-1:0] av, input logic [1:0] mv);
        logic [W-1:0] minNeg;
        minNeg        = '0;
        minNeg[W-1]   = 1'b1;
        return (mv == 2'd1) && (av == minNeg);
    endfunction

    // Runs one operation; with disturb set, scrambles the inputs and pulses
    // start while the operation is in RUN and DONE.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [1:0] mv,
                                 input bit disturb);
        int               lat;
        bit               stable;
        logic [2*W-1:0]   outHold;
        logic [2*W-1:0]   expOut;
        expOut = {av, modelResult(av, mv)};
        checkOutput("ready_before", bus.ready, 1);
        bus.start = 1'b1;
        bus.a     = av;
        bus.mode  = mv;
        @(negedge clk);
        bus.start = 1'b0;
        outHold   = bus.out;
        if (disturb) begin
            bus.a    = W'($urandom);
            bus.mode = 2'($urandom);
        end
        lat    = 0;
        stable = 1'b1;
        while (!bus.done && lat < W + 4) begin
            bus.start = disturb && (lat == 2);
            @(negedge clk);
            lat++;
            if (!bus.done && bus.out !== outHold) stable = 1'b0;
        end
        bus.start = disturb;
        checkOutput("latency", lat, W);
        checkOutput("out_stable_run", stable, 1);
        checkOutput("out", bus.out, expOut);
        checkOutput("ovf", bus.ovf, modelOvf(av, mv));
        checkOutput("ready_in_done", bus.ready, 0);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("done_single", bus.done, 0);
        checkOutput("ready_after", bus.ready, 1);
        checkOutput("out_hold", bus.out, expOut);
    endtask

    initial begin
        int doneSeen;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.mode   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out", bus.out, 0);
        checkOutput("rst_ovf", bus.ovf, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_ready", bus.ready, 1);
        rst_n = 1'b1;

        applyStimulus(8'hA5, 2'd0, 1'b0);
        checkOutput("dir_a5", bus.out, 16'hA55A);
        applyStimulus(8'h06, 2'd1, 1'b0);
        checkOutput("dir_06", bus.out, 16'h06FA);
        applyStimulus(8'h80, 2'd1, 1'b0);
        checkOutput("dir_80_ovf", bus.ovf, 1);
        applyStimulus(8'h00, 2'd1, 1'b0);
        checkOutput("dir_00_ovf", bus.ovf, 0);
        applyStimulus(8'h3C, 2'd2, 1'b1);
        checkOutput("dir_3c", bus.out, 16'h3C3C);

        // Abort an operation with reset on its fourth RUN edge.
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.mode  = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        checkOutput("abort_ready", bus.ready, 1);
        checkOutput("abort_out", bus.out, 0);
        checkOutput("abort_ovf", bus.ovf, 0);
        doneSeen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        applyStimulus(8'h0F, 2'd3, 1'b0);
        checkOutput("dir_0f_m3", bus.out, 16'h0FF0);

        for (int n = 0; n < 24; n++) begin
            applyStimulus(W'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
